// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op codes and UART-interface FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_check.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_check
// Description : Flags whether a received byte is a supported ALU op code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_check
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] op_byte,
    output logic               valid
);

    logic upper_zero;

    // Bits above the op field must be clear for the byte to be an op code.
    assign upper_zero = ((op_byte >> NB_OP) == '0);

    always_comb begin
        valid = 1'b0;
        case (op_byte[NB_OP-1:0])
            NB_OP'(OP_ADD),
            NB_OP'(OP_SUB),
            NB_OP'(OP_AND),
            NB_OP'(OP_OR),
            NB_OP'(OP_XOR),
            NB_OP'(OP_SRA),
            NB_OP'(OP_SRL),
            NB_OP'(OP_NOR): valid = upper_zero;
            default:        valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_if
// Description : Collects A, B and op bytes from a UART receiver, drives the
//               ALU and returns its result through the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation_code,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_error
);

    state_t state;
    logic   op_valid;

    alu_op_check #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_op_check (
        .op_byte (i_rx_data),
        .valid   (op_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= WAIT_A;
            o_data_a         <= '0;
            o_data_b         <= '0;
            o_operation_code <= '0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_busy           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_error    <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        state    <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        if (op_valid) begin
                            o_operation_code <= i_rx_data[NB_OP-1:0];
                            o_busy           <= 1'b1;
                            state            <= SEND;
                        end else begin
                            o_error <= 1'b1;
                            state   <= WAIT_A;
                        end
                    end
                end
                SEND: begin
                    // ALU output has settled on the operands registered last cycle.
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                    if (i_rx_done) begin
                        o_error <= 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (i_rx_done) begin
                        o_error <= 1'b1;
                    end
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_uart_if
// Description : Self-checking bench for alu_uart_if with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_uart_if;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op_code;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       error;

    int vectors     = 0;
    int miscompares = 0;
    logic [5:0] exp_op = '0;
    logic [7:0] exp_tx = '0;

    always #5 clk = ~clk;

    alu_uart_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_done        (rx_done),
        .i_alu_result     (alu_result),
        .i_tx_done        (tx_done),
        .o_data_a         (data_a),
        .o_data_b         (data_b),
        .o_operation_code (op_code),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .o_busy           (busy),
        .o_error          (error)
    );

    function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit op_is_valid(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h22) || (b == 8'h24) || (b == 8'h25) ||
               (b == 8'h26) || (b == 8'h03) || (b == 8'h02) || (b == 8'h27);
    endfunction

    always_comb alu_result = alu_calc(data_a, data_b, op_code);

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Sends A, B, op; returns at the negedge where tx_start is expected (valid op).
    task automatic run_to_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        vectors++;
        if (data_a !== a) begin
            miscompares++;
            $display("FAIL load_a: got %02h want %02h", data_a, a);
        end
        send_byte(b);
        vectors++;
        if (data_b !== b) begin
            miscompares++;
            $display("FAIL load_b: got %02h want %02h", data_b, b);
        end
        send_byte(op);
        vectors++;
        if (tx_start !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL early_start: start=%b busy=%b err=%b want 0 1 0", tx_start, busy, error);
        end
        exp_op = op[5:0];
        exp_tx = alu_calc(a, b, op[5:0]);
        @(negedge clk);
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== exp_tx || op_code !== exp_op) begin
            miscompares++;
            $display("FAIL tx_start: start=%b data=%02h op=%02h want 1 %02h %02h",
                     tx_start, tx_data, op_code, exp_tx, exp_op);
        end
    endtask

    task automatic finish_tx(input int gap);
        @(negedge clk);
        vectors++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pulse: start=%b busy=%b want 0 1", tx_start, busy);
        end
        repeat (gap) @(negedge clk);
        pulse_tx_done();
        vectors++;
        if (busy !== 1'b0 || tx_data !== exp_tx) begin
            miscompares++;
            $display("FAIL tx_done: busy=%b data=%02h want 0 %02h", busy, tx_data, exp_tx);
        end
    endtask

    task automatic run_invalid(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0 || op_code !== exp_op) begin
            miscompares++;
            $display("FAIL bad_op: err=%b busy=%b op=%02h want 1 0 %02h", error, busy, op_code, exp_op);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (error !== 1'b0 || tx_start !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_op_after: err=%b start=%b want 0 0", error, tx_start);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_done = 1'b1;
        tx_done = 1'b1;
        rx_data = 8'h5A;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        rst = 1'b0;
        vectors++;
        if ({data_a, data_b, op_code, tx_data, tx_start, busy, error} !== '0) begin
            miscompares++;
            $display("FAIL reset: a=%02h b=%02h op=%02h tx=%02h st=%b busy=%b err=%b want all 0",
                     data_a, data_b, op_code, tx_data, tx_start, busy, error);
        end
        exp_op = '0;
        exp_tx = '0;
    endtask

    task automatic test_directed();
        run_to_start(8'h05, 8'h03, 8'h20);
        finish_tx(2);
        run_to_start(8'h03, 8'h05, 8'h22);
        finish_tx(0);
        run_to_start(8'h7F, 8'h01, 8'h20);
        vectors++;
        if (tx_data !== 8'h80) begin
            miscompares++;
            $display("FAIL wrap: got %02h want 80", tx_data);
        end
        finish_tx(1);
        run_invalid(8'h0F, 8'hF0, 8'h3F);
        run_to_start(8'h01, 8'h01, 8'h25);
        finish_tx(0);
    endtask

    task automatic test_overrun();
        logic [7:0] hold_a;
        run_to_start(8'h12, 8'h34, 8'h26);
        hold_a = data_a;
        @(negedge clk);
        send_byte(8'hAA);
        vectors++;
        if (error !== 1'b1 || data_a !== hold_a || tx_data !== exp_tx || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: err=%b a=%02h tx=%02h busy=%b want 1 %02h %02h 1",
                     error, data_a, tx_data, busy, hold_a, exp_tx);
        end
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0 || data_a !== hold_a) begin
            miscompares++;
            $display("FAIL overrun_txdone: err=%b busy=%b a=%02h want 1 0 %02h", error, busy, data_a, hold_a);
        end
        pulse_tx_done();
        run_to_start(8'h09, 8'h04, 8'h24);
        finish_tx(0);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_op = '0;
        exp_tx = '0;
        run_to_start(8'h02, 8'h03, 8'h20);
        vectors++;
        if (tx_data !== 8'h05) begin
            miscompares++;
            $display("FAIL reset_partial: got %02h want 05", tx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_op = '0;
        exp_tx = '0;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (tx_start !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_wait_tx: start=%b busy=%b want 0 0", tx_start, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        logic [7:0] a, b, op;
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) op = 8'($urandom);
            else op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) pulse_tx_done();
            if (op_is_valid(op)) begin
                run_to_start(a, b, op);
                finish_tx($urandom_range(0, 3));
            end else begin
                run_invalid(a, b, op);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
